spi_master_ctrl: RTL
====================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter: CLK_DIV, default 4, clk_i cycles per SCLK half-period; legal range 1..255.
REQ-002 clk_i  input  1  system clock; all state changes occur on rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  request one 8-bit transfer; sampled only in IDLE.
REQ-005 tx_data_i  input  8  byte to transmit; captured in the start-accept cycle.
REQ-006 busy_o  output  1  high whenever state is not IDLE.
REQ-007 done_o  output  1  single-cycle pulse at transfer completion.
REQ-008 rx_data_o  output  8  received byte; valid from the done_o cycle and held until the next done_o.
REQ-009 sclk_o  output  1  SPI clock; idle high.
REQ-010 csn_o  output  1  chip select, active-low.
REQ-011 mosi_o  output  1  serial data out, MSB first.
REQ-012 miso_i  input  1  serial data in, MSB first.

Function
REQ-013 SPI mode 3: mosi_o changes on SCLK falling edges; miso_i sampled on SCLK rising edges.
REQ-014 FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-015 IDLE -> SETUP when start_i=1 (cycle 0); tx_data_i latched; csn_o low from cycle 1.
REQ-016 SETUP lasts CLK_DIV cycles (cycles 1..CLK_DIV), sclk_o high, mosi_o = tx bit 7.
REQ-017 SHIFT: 16 half-periods of CLK_DIV cycles each; first falling edge at cycle CLK_DIV+1.
REQ-018 At each falling edge mosi_o presents the next bit (7 down to 0).
REQ-019 At each rising edge, the miso_i value present in the preceding cycle is shifted into rx LSB.
REQ-020 8th rising edge at cycle 16*CLK_DIV+1 -> HOLD; sclk_o stays high for CLK_DIV cycles.
REQ-021 HOLD -> DONE at cycle 17*CLK_DIV+1: csn_o high, done_o=1, rx_data_o updated, mosi_o=0.
REQ-022 DONE -> IDLE after exactly one cycle, unconditionally.
REQ-023 start_i while busy_o=1 (including the DONE cycle) is ignored, not queued.
REQ-024 start_i in the first IDLE cycle after DONE is accepted; back-to-back gap is one csn_o-high cycle.
REQ-025 Bit counter 3 bits, half-period counter 8 bits; neither wraps outside its active state.
REQ-026 mosi_o = 0 whenever csn_o = 1.
REQ-027 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-028 While rstn_i=0, at any time including mid-transfer: state IDLE, sclk_o=1, csn_o=1, mosi_o=0, busy_o=0, done_o=0, rx_data_o=8'h00, all counters 0.
REQ-029 After rstn_i deasserts, the first start_i is accepted on the first rising clk_i edge with rstn_i=1.
REQ-030 A transfer cut off by reset does not produce done_o and does not update rx_data_o.

Structure
REQ-031 Package spi_pkg holds the FSM state encoding, SPI_DATA_W=8, and the SPI mode constants (CPOL=1, CPHA=1).
REQ-032 Sub-module spi_sclk_gen holds the half-period divider and emits one-cycle fall/rise strobes; spi_master_ctrl instantiates it once.
REQ-033 The TX/RX shift registers are internal to spi_master_ctrl and are not separate instances.

Verification
REQ-034 CLK_DIV=2, miso_i looped back to mosi_o, tx 8'hA5 -> rx_data_o=8'hA5, done_o at cycle 35, csn_o low for cycles 1..34.
REQ-035 CLK_DIV=2, miso_i=1, tx 8'h3C -> mosi_o bit sequence 0,0,1,1,1,1,0,0; rx_data_o=8'hFF.
REQ-036 start_i pulsed at cycles 5 and 35 of an active transfer -> exactly one done_o, and tx_data_i changes at those cycles have no effect.
REQ-037 rstn_i low during bit 3 -> same cycle: csn_o=1, sclk_o=1, busy_o=0; no done_o; rx_data_o=8'h00.
REQ-038 CLK_DIV=1, two back-to-back starts (8'h01, 8'h80), loopback -> done_o at cycles 18 and 37, rx values 8'h01 then 8'h80.
REQ-039 Checker: sclk_o only toggles while csn_o=0, and each transfer has exactly 8 rising edges.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI constants and FSM state encoding for the SPI master controller.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_HALF_W = 8;
  localparam int SPI_BIT_W  = 3;

  // Mode 3: clock idles high, data sampled on the trailing (rising) edge.
  localparam logic SPI_CPOL = 1'b1;
  localparam logic SPI_CPHA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider: owns the registered SCLK level and emits one-cycle
// strobes in the cycle before SCLK falls or rises.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en_i,
  input  logic toggle_i,
  output logic tick_o,
  output logic fall_o,
  output logic rise_o,
  output logic sclk_o
);

  localparam logic [SPI_HALF_W-1:0] DIV_M1 = SPI_HALF_W'(CLK_DIV - 1);

  logic [SPI_HALF_W-1:0] cnt_q, cnt_d;
  logic                  sclk_q, sclk_d;

  always_comb begin
    tick_o = en_i && (cnt_q == DIV_M1);
    cnt_d  = '0;
    if (en_i && !tick_o) cnt_d = cnt_q + 1'b1;
    fall_o = tick_o && toggle_i && sclk_q;
    rise_o = tick_o && toggle_i && !sclk_q;
    sclk_d = sclk_q;
    if (!en_i)                 sclk_d = SPI_CPOL;
    else if (fall_o || rise_o) sclk_d = ~sclk_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      sclk_q <= SPI_CPOL;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-byte SPI master (mode 3): SETUP / 8-bit SHIFT / HOLD framing with
// registered outputs and a one-cycle done pulse carrying the received byte.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [SPI_DATA_W-1:0] tx_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [SPI_DATA_W-1:0] rx_data_o,
  output logic                  sclk_o,
  output logic                  csn_o,
  output logic                  mosi_o,
  input  logic                  miso_i
);

  localparam logic SAMPLE_ON_RISE = SPI_CPOL ~^ SPI_CPHA;

  spi_state_e            state_q, state_d;
  logic [SPI_DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [SPI_DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_DATA_W-1:0] rx_data_q, rx_data_d;
  logic [SPI_BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  mosi_q, mosi_d;
  logic                  csn_q, csn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic gen_en, gen_toggle, tick, fall, rise, drive_stb, samp_stb;

  assign gen_en     = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign gen_toggle = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
  assign drive_stb  = SAMPLE_ON_RISE ? fall : rise;
  assign samp_stb   = SAMPLE_ON_RISE ? rise : fall;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .en_i     (gen_en),
    .toggle_i (gen_toggle),
    .tick_o   (tick),
    .fall_o   (fall),
    .rise_o   (rise),
    .sclk_o   (sclk_o)
  );

  always_comb begin
    state_d   = state_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;

    // The first drive strobe (end of SETUP) re-presents bit 7; later ones walk down.
    if (drive_stb) begin
      mosi_d  = tx_sh_q[SPI_DATA_W-1];
      tx_sh_d = {tx_sh_q[SPI_DATA_W-2:0], 1'b0};
    end
    if (samp_stb) rx_sh_d = {rx_sh_q[SPI_DATA_W-2:0], miso_i};

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (start_i) begin
          state_d = ST_SETUP;
          tx_sh_d = tx_data_i;
          rx_sh_d = '0;
          mosi_d  = tx_data_i[SPI_DATA_W-1];
        end
      end
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (samp_stb) begin
          if (bit_cnt_q == SPI_BIT_W'(SPI_DATA_W - 1)) state_d = ST_HOLD;
          else bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          mosi_d    = 1'b0;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    csn_d  = (state_d == ST_IDLE) || (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      mosi_q    <= 1'b0;
      csn_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      mosi_q    <= mosi_d;
      csn_q     <= csn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;
  assign csn_o     = csn_q;
  assign mosi_o    = mosi_q;

endmodule
